// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD engine with valid/ready handshakes.
// Uses only shifts and subtraction. Reports the compute cycle count of
// each result and flags coprime operand pairs.
module gcd_stein #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] gcd_o,
    output logic            coprime_o,
    output logic [CNTW-1:0] cycles_o
);

    // k counts common factors of two and never exceeds XLEN-1
    localparam int KW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_STRIP,
        S_ODD_A,
        S_LOOP,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [KW-1:0]   r_k;
    logic [CNTW-1:0] r_cnt;
    logic [XLEN-1:0] r_gcd;
    logic            r_coprime;
    logic [CNTW-1:0] r_cycles;

    logic            w_accept;
    logic [CNTW-1:0] w_cnt_inc;
    logic            w_a_gt_b;
    logic [XLEN-1:0] w_diff_ab;
    logic [XLEN-1:0] w_diff_ba;
    logic [XLEN-1:0] w_result;

    assign w_accept  = in_valid_i && (r_state == S_IDLE);
    // Cycle counter saturates at all-ones instead of wrapping
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_a_gt_b  = (r_a > r_b);
    assign w_diff_ab = r_a - r_b;
    assign w_diff_ba = r_b - r_a;
    // Restore the stripped common power of two
    assign w_result  = r_a << r_k;

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign gcd_o       = r_gcd;
    assign coprime_o   = r_coprime;
    assign cycles_o    = r_cycles;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((a_i == '0) || (b_i == '0)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_STRIP;
                    end
                end
            end
            S_STRIP: begin
                if (r_a[0] || r_b[0]) begin
                    w_state_next = S_ODD_A;
                end
            end
            S_ODD_A: begin
                if (r_a[0]) begin
                    w_state_next = S_LOOP;
                end
            end
            S_LOOP: begin
                if (r_b == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, Stein reduction steps and result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_gcd     <= '0;
            r_coprime <= 1'b0;
            r_cycles  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (a_i == '0) begin
                            r_gcd     <= b_i;
                            r_coprime <= (b_i == ONE);
                            r_cycles  <= '0;
                        end else if (b_i == '0) begin
                            r_gcd     <= a_i;
                            r_coprime <= (a_i == ONE);
                            r_cycles  <= '0;
                        end else begin
                            r_a <= a_i;
                            r_b <= b_i;
                            r_k <= '0;
                        end
                    end
                end
                S_STRIP: begin
                    r_cnt <= w_cnt_inc;
                    if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + 1'b1;
                    end
                end
                S_ODD_A: begin
                    r_cnt <= w_cnt_inc;
                    if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end
                end
                S_LOOP: begin
                    r_cnt <= w_cnt_inc;
                    if (r_b == '0) begin
                        r_gcd     <= w_result;
                        r_coprime <= (w_result == ONE);
                        r_cycles  <= w_cnt_inc;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (w_a_gt_b) begin
                        r_a <= r_b;
                        r_b <= w_diff_ab;
                    end else begin
                        r_b <= w_diff_ba;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/gcd_stein.md
Name: gcd_stein

Overview:
- Parametrised, handshaked successor to the team's GCD block.
- Computes gcd(a, b) of two unsigned XLEN-bit operands with the binary (Stein) algorithm: shift/subtract only, no divider.
- Uses valid/ready on input and output, reports the per-operation cycle count for workload profiling, and flags coprime results.
- Sits as a streaming arithmetic unit behind any producer/consumer that speaks valid/ready.

Parameters:
- XLEN, 32, operand and result width in bits (>= 2).
- CNTW, 16, width of the cycle counter output; saturates at all-ones.

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  block can accept operands.
- a_i  input  XLEN  operand A, unsigned.
- b_i  input  XLEN  operand B, unsigned.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- gcd_o  output  XLEN  result.
- coprime_o  output  1  result == 1.
- cycles_o  output  CNTW  compute cycles of the current result.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready_o=1; out_valid_o=0; gcd_o=0; coprime_o=0; cycles_o=0; all internal registers 0.
- Internal registers: ra and rb (XLEN bits), k (shift count, clog2(XLEN)+1 bits), cnt (CNTW bits).
- States: IDLE, STRIP, ODD_A, LOOP, DONE. in_ready_o=1 only in IDLE. out_valid_o=1 only in DONE.
- IDLE: handshake is in_valid_i & in_ready_o.
  - a_i==0: gcd_o<=b_i, cnt<=0, go DONE.
  - Else b_i==0: gcd_o<=a_i, cnt<=0, go DONE. gcd(0,0)=0.
  - Else: ra<=a_i, rb<=b_i, k<=0, cnt<=0, go STRIP.
- In STRIP, ODD_A and LOOP, cnt increments by 1 every cycle, saturating.
- STRIP: if ra[0]==0 and rb[0]==0, then ra>>=1, rb>>=1, k++. Otherwise go ODD_A with no data change.
- ODD_A: if ra[0]==0, then ra>>=1. Otherwise go LOOP with no data change.
- LOOP (invariant: ra odd):
  - rb==0: gcd_o<=ra<<k, go DONE.
  - Else if rb[0]==0: rb>>=1.
  - Else if ra>rb: ra<=rb, rb<=ra-rb.
  - Else: rb<=rb-ra.
  - Subtraction is XLEN-bit unsigned and never underflows by construction.
- On entry to DONE: cycles_o<=final cnt; coprime_o<=(result==1).
- DONE: hold gcd_o, coprime_o and cycles_o stable while out_ready_i=0. When out_ready_i=1, go IDLE.
  - The next operand pair is accepted no earlier than the following cycle; there is no same-cycle pass-through.
- gcd_o, coprime_o and cycles_o keep their last values in IDLE until overwritten by the next result.
- Latency:
  - Zero operand: out_valid_o rises the cycle after accept; cycles_o=0.
  - Otherwise: out_valid_o rises 1 cycle after the last compute cycle.
  - Worst case is O(2*XLEN) compute cycles.
- in_valid_i while not in IDLE is ignored. a_i and b_i are sampled only at the handshake.
- rst_i asserted mid-operation: immediately returns to the reset values. A pending result is discarded.
- Maximum operands (all-ones, all-ones): gcd = all-ones, no overflow.
- k never exceeds XLEN-1 for non-zero operands.

Test Plan:
- Reset and idle: assert rst_i mid-LOOP on gcd(48,18) -> all outputs take reset values asynchronously; in_ready_o=1 after release; no spurious out_valid_o.
- gcd(48,18): out_valid_o 11 cycles after accept; gcd_o=6, cycles_o=10, coprime_o=0.
- Zero cases:
  - (0,0) -> gcd_o=0, cycles_o=0.
  - (0,35) -> 35.
  - (12,0) -> 12.
  - Each out_valid_o arrives the cycle after accept.
- Coprime and extremes (XLEN=32):
  - (17,5) -> 1, coprime_o=1.
  - (0xFFFFFFFF,0xFFFFFFFF) -> 0xFFFFFFFF.
  - (0x80000000,0x40000000) -> 0x40000000 (k=30).
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> outputs stable; in_ready_o=0; a new in_valid_i is ignored. Release -> IDLE next cycle; the next pair is accepted only after that.
- Random: 10k random pairs at XLEN=8 and XLEN=32 with random out_ready_i -> match a software reference GCD; cycles_o monotonic per model and never exceeds 2*XLEN+4.
